ifetch_align: RTL and testbench
===============================

Name: ifetch_align

Overview:
- Instruction fetch and alignment stage. Sits directly downstream of PCUnit and upstream of decode/IMMGen.
- Reads 32-bit words from instruction memory at the current PC and delivers one aligned instruction (IR) per handshake.
- Supports halfword-aligned PCs and 16-bit compressed instructions, using a one-halfword spare buffer.
- Drives PCUnit's load and sel[1]; PCUnit sel[0] stays external (redirect).

Parameters:
- none; datapath fixed at 32 bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- PC  in  32  current PC from PCUnit
- flush  in  1  redirect; PCUnit loads a new PC at this edge
- imem_req  out  1  memory read request
- imem_addr  out  32  word address, bits[1:0]=00
- imem_ack  in  1  read data valid; may arrive in the request cycle
- imem_rdata  in  32  read data
- ir  out  32  instruction to decode
- ir_valid  out  1  ir holds an instruction
- ir_ready  in  1  decode accepts ir
- ir_c  out  1  ir is compressed; feeds PCUnit sel[1]
- pc_load  out  1  equals ir_valid & ir_ready; feeds PCUnit load

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: state=S_FETCH, ir=0, ir_valid=0, ir_c=0, spare=0, spare_valid=0, spare_addr=0, addr_q=0. imem_req=0 except in S_FETCH/S_FETCH2/S_DRAIN as below.
- Compressed test: halfword h is compressed iff h[1:0]!=2'b11.
- Compressed ir: {16'b0,h}, ir_c=1. 32-bit ir: ir_c=0.

S_FETCH, PC[1]=0:
- imem_req=1, imem_addr={PC[31:2],2'b00}.
- On ack with rdata[15:0] compressed: ir={16'b0,rdata[15:0]}; spare=rdata[31:16], spare_addr=PC+2, spare_valid=1.
- On ack otherwise: ir=rdata, spare_valid=0.
- Either case -> S_VALID.

S_FETCH, PC[1]=1 with spare hit (spare_valid && spare_addr==PC):
- No request.
- Spare compressed: ir={16'b0,spare}, spare_valid=0 -> S_VALID.
- Spare not compressed: -> S_FETCH2.

S_FETCH, PC[1]=1 without spare hit:
- Request word {PC[31:2],2'b00}.
- On ack: spare=rdata[31:16], spare_addr=PC.
- Upper half compressed: ir={16'b0,upper half} -> S_VALID.
- Otherwise: -> S_FETCH2.

S_FETCH2:
- imem_req=1, imem_addr={PC[31:2],2'b00}+4.
- On ack: ir={rdata[15:0],spare}; spare=rdata[31:16], spare_addr=PC+4, spare_valid=1 -> S_VALID.

S_VALID:
- ir_valid=1. ir and ir_c are held stable until ir_ready.
- On ir_ready: pc_load=1 for that cycle; PCUnit updates PC at the same edge -> S_FETCH.
- Earliest ir_valid: the cycle after ack. Spare-hit compressed path: 1 cycle after S_FETCH, no memory access.

Memory handshake:
- imem_req and imem_addr are held stable until imem_ack.
- addr_q captures imem_addr every cycle imem_req=1.

Flush (any state):
- Clears ir_valid and spare_valid.
- If a request is outstanding without ack this cycle: -> S_DRAIN. There imem_req=1, imem_addr=addr_q; the ack is consumed and its data discarded -> S_FETCH.
- Otherwise (including ack in the flush cycle, data dropped): -> S_FETCH.
- Flush overrides ir_ready; pc_load is forced to 0 in the flush cycle.

Other boundary rules:
- Wrap-around: PC+4 from 0xFFFFFFFE wraps modulo 2^32.
- rst mid-request: all state cleared immediately; a late ack while in S_FETCH with no request is ignored.
- imem_ack while imem_req=0 is ignored.

Optional Feature:
- Macro IFETCH_C_EXT_EN.
- Defined: compressed and halfword-aligned handling as above.
- Undefined: no spare buffer and no S_FETCH2; every instruction is 32-bit. ir=rdata, ir_c tied 0, PC[1] ignored (word fetch at {PC[31:2],2'b00}).

Test Plan:
1. Reset, PC=0, word@0=0x00000013, zero-wait ack -> ir=0x00000013, ir_c=0, ir_valid the cycle after ack; ir_ready=1 -> pc_load pulse.
2. PC=0, word@0=0x45014581 -> ir=0x00004581, ir_c=1. After accept with PC=2: no imem_req; ir=0x00004501, ir_c=1 one cycle later.
3. PC=2, word@0=0x00930001, word@4=0xABCD0000 -> two requests (0x0, 0x4); ir=0x00000093; spare=0xABCD, spare_addr=6.
4. ir_valid with ir_ready=0 for 3 cycles -> ir stable, pc_load=0, imem_req=0; ready on cycle 4 -> single pc_load pulse.
5. Request at 0x100, ack delayed 3 cycles, flush in cycle 1 with new PC=0x200 -> imem_addr stays 0x100 until ack, data discarded, ir_valid=0; next request at 0x200.
6. rst asserted mid-S_FETCH2 -> all outputs return to reset values asynchronously; after release, fetch restarts at the current PC.

Source files
------------

// File: rtl/ifetch_align_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the IR handshake to decode.
interface ifetch_align_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        ir_c;
    logic        pc_load;

    modport master (output imem_req, imem_addr, ir, ir_valid, ir_c, pc_load,
                    input  imem_ack, imem_rdata, ir_ready);
    modport slave  (input  imem_req, imem_addr, ir, ir_valid, ir_c, pc_load,
                    output imem_ack, imem_rdata, ir_ready);
endinterface

// File: rtl/ifetch_align.sv
// Instruction fetch/align stage: one aligned IR per handshake from 32-bit memory words.
// Define IFETCH_C_EXT_EN for halfword PCs and 16-bit compressed instructions (spare-halfword buffer).
module ifetch_align (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    PC,
    input  logic           flush,
    ifetch_align_if.master bus
);
    typedef enum logic [1:0] {S_FETCH, S_FETCH2, S_VALID, S_DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] ir_q, ir_n;
    logic        ir_c_q, ir_c_n;
    logic [31:0] addr_q;
    logic        req;
    logic [31:0] addr;
    logic        pc_load;
    logic [31:0] word_addr;

    assign word_addr = {PC[31:2], 2'b00};

`ifdef IFETCH_C_EXT_EN
    logic [15:0] spare, spare_n;
    logic        spare_valid, spare_valid_n;
    logic [31:0] spare_addr, spare_addr_n;
    logic        spare_hit;

    function automatic logic is_comp(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    assign spare_hit = spare_valid && (spare_addr == PC);
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^PC[1:0];
`endif

    always_comb begin
        state_n = state;
        ir_n    = ir_q;
        ir_c_n  = ir_c_q;
        req     = 1'b0;
        addr    = word_addr;
        pc_load = 1'b0;
`ifdef IFETCH_C_EXT_EN
        spare_n       = spare;
        spare_valid_n = spare_valid;
        spare_addr_n  = spare_addr;
`endif
        case (state)
            S_FETCH: begin
`ifdef IFETCH_C_EXT_EN
                if (PC[1] && spare_hit) begin
                    // Upper half of the previous word already on hand: no memory access.
                    if (is_comp(spare)) begin
                        ir_n          = {16'h0000, spare};
                        ir_c_n        = 1'b1;
                        spare_valid_n = 1'b0;
                        state_n       = S_VALID;
                    end else begin
                        state_n = S_FETCH2;
                    end
                end else begin
                    req = 1'b1;
                    if (bus.imem_ack) begin
                        if (PC[1]) begin
                            spare_n       = bus.imem_rdata[31:16];
                            spare_addr_n  = PC;
                            spare_valid_n = 1'b0;
                            if (is_comp(bus.imem_rdata[31:16])) begin
                                ir_n    = {16'h0000, bus.imem_rdata[31:16]};
                                ir_c_n  = 1'b1;
                                state_n = S_VALID;
                            end else begin
                                state_n = S_FETCH2;
                            end
                        end else if (is_comp(bus.imem_rdata[15:0])) begin
                            ir_n          = {16'h0000, bus.imem_rdata[15:0]};
                            ir_c_n        = 1'b1;
                            spare_n       = bus.imem_rdata[31:16];
                            spare_addr_n  = PC + 32'd2;
                            spare_valid_n = 1'b1;
                            state_n       = S_VALID;
                        end else begin
                            ir_n          = bus.imem_rdata;
                            ir_c_n        = 1'b0;
                            spare_valid_n = 1'b0;
                            state_n       = S_VALID;
                        end
                    end
                end
`else
                req = 1'b1;
                if (bus.imem_ack) begin
                    ir_n    = bus.imem_rdata;
                    state_n = S_VALID;
                end
`endif
            end
`ifdef IFETCH_C_EXT_EN
            S_FETCH2: begin
                // Second word supplies the upper half of a 32-bit instruction straddling words.
                req  = 1'b1;
                addr = word_addr + 32'd4;
                if (bus.imem_ack) begin
                    ir_n          = {bus.imem_rdata[15:0], spare};
                    ir_c_n        = 1'b0;
                    spare_n       = bus.imem_rdata[31:16];
                    spare_addr_n  = PC + 32'd4;
                    spare_valid_n = 1'b1;
                    state_n       = S_VALID;
                end
            end
`endif
            S_VALID: begin
                if (bus.ir_ready) begin
                    pc_load = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_DRAIN: begin
                req  = 1'b1;
                addr = addr_q;
                if (bus.imem_ack) state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase

        // Redirect wins over everything; an unanswered request must still be drained.
        if (flush) begin
            pc_load = 1'b0;
            ir_n    = ir_q;
            ir_c_n  = ir_c_q;
            state_n = (req && !bus.imem_ack) ? S_DRAIN : S_FETCH;
`ifdef IFETCH_C_EXT_EN
            spare_valid_n = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_FETCH;
            ir_q   <= 32'h0;
            ir_c_q <= 1'b0;
            addr_q <= 32'h0;
`ifdef IFETCH_C_EXT_EN
            spare       <= 16'h0;
            spare_valid <= 1'b0;
            spare_addr  <= 32'h0;
`endif
        end else begin
            state  <= state_n;
            ir_q   <= ir_n;
            ir_c_q <= ir_c_n;
            if (req) addr_q <= addr;
`ifdef IFETCH_C_EXT_EN
            spare       <= spare_n;
            spare_valid <= spare_valid_n;
            spare_addr  <= spare_addr_n;
`endif
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = addr;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = (state == S_VALID);
    assign bus.ir_c      = ir_c_q;
    assign bus.pc_load   = pc_load;
endmodule

// File: tb/tb_ifetch_align.sv
// Directed bench for ifetch_align with a word memory whose ack latency is set per scenario.
`timescale 1ns/1ps
module tb_ifetch_align;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        flush;
    int          checks;
    int          errors;
    int          ack_delay;
    int          wait_cnt = 0;
    logic [31:0] mem [0:255];

    ifetch_align_if bus();

    ifetch_align dut (
        .clk   (clk),
        .rst   (rst),
        .PC    (PC),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory answers once a request has been pending for ack_delay cycles (0 = same cycle).
    assign bus.imem_ack   = bus.imem_req && (wait_cnt >= ack_delay);
    assign bus.imem_rdata = mem[bus.imem_addr[9:2]];

    always @(posedge clk) begin
        if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.ir !== 32'h0) begin errors++; $display("FAIL reset_ir got %h want %h", bus.ir, 32'h0); end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %b want 0", bus.ir_valid); end
        checks++; if (bus.ir_c !== 1'b0) begin errors++; $display("FAIL reset_ir_c got %b want 0", bus.ir_c); end
        checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL reset_pc_load got %b want 0", bus.pc_load); end
        rst = 1'b0;
    endtask

    task automatic test_word;
        mem[0] = 32'h00000013;
        PC = 32'h0;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL word_req got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL word_addr got %h want %h", bus.imem_addr, 32'h0); end
        tick();
        checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL word_valid got %b want 1", bus.ir_valid); end
        checks++; if (bus.ir !== 32'h00000013) begin errors++; $display("FAIL word_ir got %h want %h", bus.ir, 32'h00000013); end
        checks++; if (bus.ir_c !== 1'b0) begin errors++; $display("FAIL word_ir_c got %b want 0", bus.ir_c); end
        bus.ir_ready = 1'b1;
        #1;
        checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL word_pc_load got %b want 1", bus.pc_load); end
        tick();
        bus.ir_ready = 1'b0;
        PC = 32'h4;
        #1;
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL word_after_valid got %b want 0", bus.ir_valid); end
        checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL word_after_pc_load got %b want 0", bus.pc_load); end
    endtask

    task automatic test_compressed;
        mem[0] = 32'h45014581;
        PC = 32'h0;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL comp_req got %b want 1", bus.imem_req); end
        tick();
`ifdef IFETCH_C_EXT_EN
        checks++; if (bus.ir !== 32'h00004581) begin errors++; $display("FAIL comp_ir0 got %h want %h", bus.ir, 32'h00004581); end
        checks++; if (bus.ir_c !== 1'b1) begin errors++; $display("FAIL comp_ir_c0 got %b want 1", bus.ir_c); end
        bus.ir_ready = 1'b1;
        #1;
        checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL comp_pc_load got %b want 1", bus.pc_load); end
        tick();
        bus.ir_ready = 1'b0;
        PC = 32'h2;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL comp_spare_req got %b want 0", bus.imem_req); end
        tick();
        checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL comp_valid1 got %b want 1", bus.ir_valid); end
        checks++; if (bus.ir !== 32'h00004501) begin errors++; $display("FAIL comp_ir1 got %h want %h", bus.ir, 32'h00004501); end
        checks++; if (bus.ir_c !== 1'b1) begin errors++; $display("FAIL comp_ir_c1 got %b want 1", bus.ir_c); end
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        PC = 32'h4;
`else
        checks++; if (bus.ir !== 32'h45014581) begin errors++; $display("FAIL comp_ir0 got %h want %h", bus.ir, 32'h45014581); end
        checks++; if (bus.ir_c !== 1'b0) begin errors++; $display("FAIL comp_ir_c0 got %b want 0", bus.ir_c); end
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        PC = 32'h2;
        #1;
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL comp_pc1_addr got %h want %h", bus.imem_addr, 32'h0); end
        tick();
        checks++; if (bus.ir !== 32'h45014581) begin errors++; $display("FAIL comp_ir1 got %h want %h", bus.ir, 32'h45014581); end
        checks++; if (bus.ir_c !== 1'b0) begin errors++; $display("FAIL comp_ir_c1 got %b want 0", bus.ir_c); end
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        PC = 32'h4;
`endif
    endtask

    task automatic test_misaligned;
        mem[0] = 32'h00930001;
        mem[1] = 32'hABCD0000;
        PC = 32'h2;
        #1;
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL mis_addr0 got %h want %h", bus.imem_addr, 32'h0); end
        tick();
`ifdef IFETCH_C_EXT_EN
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL mis_req1 got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL mis_addr1 got %h want %h", bus.imem_addr, 32'h4); end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL mis_valid_early got %b want 0", bus.ir_valid); end
        tick();
        checks++; if (bus.ir !== 32'h00000093) begin errors++; $display("FAIL mis_ir got %h want %h", bus.ir, 32'h00000093); end
        checks++; if (bus.ir_c !== 1'b0) begin errors++; $display("FAIL mis_ir_c got %b want 0", bus.ir_c); end
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        PC = 32'h6;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mis_spare_req got %b want 0", bus.imem_req); end
        tick();
        checks++; if (bus.ir !== 32'h0000ABCD) begin errors++; $display("FAIL mis_spare_ir got %h want %h", bus.ir, 32'h0000ABCD); end
        checks++; if (bus.ir_c !== 1'b1) begin errors++; $display("FAIL mis_spare_ir_c got %b want 1", bus.ir_c); end
`else
        checks++; if (bus.ir !== 32'h00930001) begin errors++; $display("FAIL mis_ir got %h want %h", bus.ir, 32'h00930001); end
        checks++; if (bus.ir_c !== 1'b0) begin errors++; $display("FAIL mis_ir_c got %b want 0", bus.ir_c); end
`endif
    endtask

    task automatic test_stall;
        logic [31:0] exp_ir;
`ifdef IFETCH_C_EXT_EN
        exp_ir = 32'h0000ABCD;
`else
        exp_ir = 32'h00930001;
`endif
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, bus.ir_valid); end
            checks++; if (bus.ir !== exp_ir) begin errors++; $display("FAIL stall_ir[%0d] got %h want %h", i, bus.ir, exp_ir); end
            checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL stall_pc_load[%0d] got %b want 0", i, bus.pc_load); end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b want 0", i, bus.imem_req); end
            tick();
        end
        bus.ir_ready = 1'b1;
        #1;
        checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL stall_accept got %b want 1", bus.pc_load); end
        tick();
        bus.ir_ready = 1'b0;
        checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL stall_single_pulse got %b want 0", bus.pc_load); end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL stall_after_valid got %b want 0", bus.ir_valid); end
    endtask

    task automatic test_flush;
        ack_delay = 3;
        mem[8'h40] = 32'h11111113;
        mem[8'h80] = 32'h22222223;
        PC = 32'h100;
        flush = 1'b1;
        #1;
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL flush_addr0 got %h want %h", bus.imem_addr, 32'h100); end
        tick();
        flush = 1'b0;
        PC = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL drain_req[%0d] got %b want 1", i, bus.imem_req); end
            checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL drain_addr[%0d] got %h want %h", i, bus.imem_addr, 32'h100); end
            checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL drain_valid[%0d] got %b want 0", i, bus.ir_valid); end
            tick();
        end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got %b want 0", bus.ir_valid); end
        checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL flush_new_addr got %h want %h", bus.imem_addr, 32'h200); end
        ack_delay = 0;
        tick();
        checks++; if (bus.ir !== 32'h22222223) begin errors++; $display("FAIL flush_new_ir got %h want %h", bus.ir, 32'h22222223); end
        checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL flush_new_valid got %b want 1", bus.ir_valid); end
    endtask

    task automatic test_flush_valid;
        mem[8'hC0] = 32'h33333333;
        bus.ir_ready = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL fv_pc_load got %b want 0", bus.pc_load); end
        tick();
        flush = 1'b0;
        bus.ir_ready = 1'b0;
        PC = 32'h300;
        #1;
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL fv_valid got %b want 0", bus.ir_valid); end
        checks++; if (bus.imem_addr !== 32'h300) begin errors++; $display("FAIL fv_addr got %h want %h", bus.imem_addr, 32'h300); end
        tick();
        checks++; if (bus.ir !== 32'h33333333) begin errors++; $display("FAIL fv_ir got %h want %h", bus.ir, 32'h33333333); end
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
    endtask

    task automatic test_wrap;
        mem[255] = 32'h00B70001;
        mem[0]   = 32'h12340000;
        PC = 32'hFFFFFFFE;
        #1;
        checks++; if (bus.imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr0 got %h want %h", bus.imem_addr, 32'hFFFFFFFC); end
        tick();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h want %h", bus.imem_addr, 32'h0); end
        tick();
        checks++; if (bus.ir !== 32'h000000B7) begin errors++; $display("FAIL wrap_ir got %h want %h", bus.ir, 32'h000000B7); end
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        PC = 32'h2;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL wrap_spare_req got %b want 0", bus.imem_req); end
        tick();
        checks++; if (bus.ir !== 32'h00001234) begin errors++; $display("FAIL wrap_spare_ir got %h want %h", bus.ir, 32'h00001234); end
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] exp_ir;
`ifdef IFETCH_C_EXT_EN
        mem[0] = 32'h00930001;
        mem[1] = 32'hABCD0000;
        PC = 32'h2;
        ack_delay = 0;
        tick();
        ack_delay = 5;
        #1;
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL rmid_fetch2_addr got %h want %h", bus.imem_addr, 32'h4); end
        exp_ir = 32'h00000093;
`else
        mem[4] = 32'h44444443;
        PC = 32'h10;
        ack_delay = 5;
        tick();
        #1;
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL rmid_pending_addr got %h want %h", bus.imem_addr, 32'h10); end
        exp_ir = 32'h44444443;
`endif
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.ir !== 32'h0) begin errors++; $display("FAIL rmid_ir got %h want %h", bus.ir, 32'h0); end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", bus.ir_valid); end
        checks++; if (bus.ir_c !== 1'b0) begin errors++; $display("FAIL rmid_ir_c got %b want 0", bus.ir_c); end
        tick();
        rst = 1'b0;
        ack_delay = 0;
        #1;
`ifdef IFETCH_C_EXT_EN
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_restart_addr got %h want %h", bus.imem_addr, 32'h0); end
        tick();
`else
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL rmid_restart_addr got %h want %h", bus.imem_addr, 32'h10); end
`endif
        tick();
        checks++; if (bus.ir !== exp_ir) begin errors++; $display("FAIL rmid_restart_ir got %h want %h", bus.ir, exp_ir); end
        checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL rmid_restart_valid got %b want 1", bus.ir_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        PC = 32'h0;
        flush = 1'b0;
        ack_delay = 0;
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_compressed();
        test_misaligned();
        test_stall();
        test_flush();
        test_flush_valid();
`ifdef IFETCH_C_EXT_EN
        test_wrap();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
